// File: rtl/wb_spi_pkg.sv
// Shared types and constants for the Wishbone SPI master.
package wb_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam int unsigned BIT_CNT_W           = 3;
    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned DEFAULT_HALF_PERIOD = 2;

endpackage

// File: rtl/bit_sync.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone classic byte slave running one SPI mode-0, MSB-first exchange per strobe.
// Optional feature macro SPI_SDI_SYNC_EN: MISO passes through a 2-flop synchroniser
// and is sampled on the SCK falling edge instead of the rising edge.
module wb_spi_master
    import wb_spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cyc,
    input  logic       i_stb,
    input  logic       i_we,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    output logic       o_ack,
    input  logic       i_sdi,
    output logic       o_sdo,
    output logic       o_ss,
    output logic       o_sck
);

    state_t              state;
    logic [BYTE_W-1:0]   tx_reg;
    logic [BYTE_W-1:0]   rx_reg;
    logic [BYTE_W-1:0]   rx_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]          hp_cnt;
    logic                hp_last;
    logic                unused;

    // Write enable carries no meaning for the exchange itself.
    assign unused  = i_we;
    assign hp_last = (hp_cnt == 8'(HALF_PERIOD - 1));

`ifdef SPI_SDI_SYNC_EN
    logic sdi_s;

    bit_sync u_sdi_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_sdi),
        .q     (sdi_s)
    );

    // Receive shift happens on the falling edge, so the last bit must be folded in
    // on the same edge that publishes the byte.
    assign rx_next = {rx_reg[BYTE_W-2:0], sdi_s};
`else
    assign rx_next = rx_reg;
`endif

    // Transfer sequencer: chip-select tracking, SCK generation, shifting and ack.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            tx_reg  <= '0;
            rx_reg  <= '0;
            bit_cnt <= '0;
            hp_cnt  <= '0;
            o_ss    <= 1'b1;
            o_sck   <= 1'b0;
            o_sdo   <= 1'b0;
            o_ack   <= 1'b0;
            o_dat   <= '0;
        end else begin
            o_ss  <= ~i_cyc;
            o_ack <= 1'b0;
            if (!i_cyc) begin
                state  <= IDLE;
                o_sck  <= 1'b0;
                hp_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_stb && !o_ack) begin
                            tx_reg  <= i_dat;
                            o_sdo   <= i_dat[BYTE_W-1];
                            bit_cnt <= '0;
                            hp_cnt  <= '0;
                            state   <= LOW;
                        end
                    end
                    LOW: begin
                        if (hp_last) begin
                            hp_cnt <= '0;
                            o_sck  <= 1'b1;
`ifndef SPI_SDI_SYNC_EN
                            rx_reg <= {rx_reg[BYTE_W-2:0], i_sdi};
`endif
                            state  <= HIGH;
                        end else begin
                            hp_cnt <= hp_cnt + 8'd1;
                        end
                    end
                    HIGH: begin
                        if (hp_last) begin
                            hp_cnt <= '0;
                            o_sck  <= 1'b0;
`ifdef SPI_SDI_SYNC_EN
                            rx_reg <= rx_next;
`endif
                            if (bit_cnt == '1) begin
                                o_dat <= rx_next;
                                o_ack <= 1'b1;
                                state <= IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_reg  <= {tx_reg[BYTE_W-2:0], 1'b0};
                                o_sdo   <= tx_reg[BYTE_W-2];
                                state   <= LOW;
                            end
                        end else begin
                            hp_cnt <= hp_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_spi_master.sv
// Self-checking bench for wb_spi_master (default build, HALF_PERIOD = 2).
module tb_wb_spi_master;

    localparam int unsigned HP = 2;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cyc   = 1'b0;
    logic       i_stb   = 1'b0;
    logic       i_we    = 1'b0;
    logic [7:0] i_dat   = '0;
    logic       i_sdi   = 1'b0;
    logic [7:0] o_dat;
    logic       o_ack;
    logic       o_sdo;
    logic       o_ss;
    logic       o_sck;

    wb_spi_master #(.HALF_PERIOD(HP)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_cyc   (i_cyc),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_dat   (i_dat),
        .o_dat   (o_dat),
        .o_ack   (o_ack),
        .i_sdi   (i_sdi),
        .o_sdo   (o_sdo),
        .o_ss    (o_ss),
        .o_sck   (o_sck)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // monitor state
    int         rises       = 0;
    logic [7:0] sdo_bits    = '0;
    logic       sck_prev    = 1'b0;
    int         ack_cnt     = 0;
    int         ss_high_cnt = 0;
    // stimulus controls read by the monitor
    int         sdi_mode    = 0;   // 0: loopback of o_sdo, 1: drive pat
    logic [7:0] pat         = '0;
    logic       watch_ss    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_ack && n < 200);
        if (!o_ack) check("ack_timeout", 32'(n), 32'd33);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] rx, input int mode,
                        input logic we, output int n);
        sdi_mode = mode;
        pat      = rx;
        i_dat    = tx;
        i_we     = we;
        i_cyc    = 1'b1;
        i_stb    = 1'b1;
        sb.push_back('{tx: tx, rx: rx});
        wait_ack(n);
        i_stb = 1'b0;
        i_cyc = 1'b0;
    endtask

    // Scoreboard side: track SCK pulses and MOSI bits, drive MISO, compare on ack.
    always @(negedge i_clk) begin
        if (o_sck && !sck_prev) begin
            rises++;
            sdo_bits = {sdo_bits[6:0], o_sdo};
        end
        if (watch_ss && o_ss) ss_high_cnt++;
        if (o_ack) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rx_byte", 32'(o_dat), 32'(e.rx));
                check("tx_bits", 32'(sdo_bits), 32'(e.tx));
                check("sck_pulses", 32'(rises), 32'd8);
            end
        end
        if (o_ack || o_ss) begin
            rises    = 0;
            sdo_bits = '0;
        end
        if (sdi_mode == 0) i_sdi = o_sdo;
        else if (!o_sck && rises < 8) i_sdi = pat[7 - rises];
        sck_prev = o_sck;
    end

    initial begin
        int n;
        int acks_before;

        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (2) tick();
        check("rst_ss", 32'(o_ss), 32'd1);
        check("rst_sck", 32'(o_sck), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_dat", 32'(o_dat), 32'd0);
        check("rst_sdo", 32'(o_sdo), 32'd0);

        // loopback 0xA5 with we=1, ack latency and width
        xfer(8'hA5, 8'hA5, 0, 1'b1, n);
        check("ack_latency", 32'(n), 32'(16 * HP + 1));
        tick();
        check("ack_width", 32'(o_ack), 32'd0);
        check("dat_hold", 32'(o_dat), 32'hA5);
        repeat (2) tick();

        // we=0, transmit all ones, receive 0x3C
        xfer(8'hFF, 8'h3C, 1, 1'b0, n);
        repeat (3) tick();

        // back-to-back with cyc held and stb overlapping the first ack
        acks_before = ack_cnt;
        sdi_mode = 0;
        i_we  = 1'b1;
        i_dat = 8'h01;
        i_cyc = 1'b1;
        i_stb = 1'b1;
        sb.push_back('{tx: 8'h01, rx: 8'h01});
        tick();
        watch_ss = 1'b1;
        wait_ack(n);
        i_dat = 8'h80;
        sb.push_back('{tx: 8'h80, rx: 8'h80});
        wait_ack(n);
        i_stb = 1'b0;
        repeat (40) tick();
        check("b2b_ss_low", 32'(ss_high_cnt), 32'd0);
        check("b2b_sck_idle", 32'(o_sck), 32'd0);
        watch_ss = 1'b0;
        i_cyc = 1'b0;
        tick();
        check("b2b_ack_count", 32'(ack_cnt - acks_before), 32'd2);
        check("b2b_dat", 32'(o_dat), 32'h80);

        // abort by dropping cyc during the third SCK high phase
        acks_before = ack_cnt;
        i_dat = 8'h55;
        i_cyc = 1'b1;
        i_stb = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(rises == 3 && o_sck) && n < 200);
        check("abort_reach", 32'(rises), 32'd3);
        i_cyc = 1'b0;
        i_stb = 1'b0;
        tick();
        check("abort_sck", 32'(o_sck), 32'd0);
        check("abort_ss", 32'(o_ss), 32'd1);
        repeat (40) tick();
        check("abort_no_ack", 32'(ack_cnt - acks_before), 32'd0);
        check("abort_dat", 32'(o_dat), 32'h80);

        // reset during the second SCK high phase
        i_dat = 8'h66;
        i_cyc = 1'b1;
        i_stb = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(rises == 2 && o_sck) && n < 200);
        check("midrst_reach", 32'(rises), 32'd2);
        i_rst_n = 1'b0;
        tick();
        check("midrst_ss", 32'(o_ss), 32'd1);
        check("midrst_sck", 32'(o_sck), 32'd0);
        check("midrst_sdo", 32'(o_sdo), 32'd0);
        check("midrst_ack", 32'(o_ack), 32'd0);
        check("midrst_dat", 32'(o_dat), 32'd0);
        i_cyc = 1'b0;
        i_stb = 1'b0;
        tick();
        i_rst_n = 1'b1;
        repeat (2) tick();
        xfer(8'hC3, 8'hC3, 0, 1'b1, n);
        check("post_rst_latency", 32'(n), 32'(16 * HP + 1));
        repeat (3) tick();

        check("total_acks", 32'(ack_cnt), 32'd5);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
